// File: rtl/mul_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl_pkg
// Shared constants for the multiply sequencer:
//   - operand/result and opcode widths
//   - opcode encodings (MUL / MULXSS / MULXSU / MULXUU)
//   - sequencer state encoding
// No ports; imported by the interface, the sequencer top and the high-word fixer.
// -----------------------------------------------------------------------------
package mul_seq_ctrl_pkg;

    // Only 32 is supported: the multiply cell is a fixed 3 x 16x16 array.
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned HALF_W = 16;

    // Width of the carry kept between the low-word and high-word passes.
    localparam int unsigned CARRY_W = 18;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam op_t OP_MUL    = 2'd0;
    localparam op_t OP_MULXSS = 2'd1;
    localparam op_t OP_MULXSU = 2'd2;
    localparam op_t OP_MULXUU = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE1 = 3'd1;
    localparam logic [2:0] ST_CAP1   = 3'd2;
    localparam logic [2:0] ST_ISSUE2 = 3'd3;
    localparam logic [2:0] ST_CAP2   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // High-word ops that treat operand A as signed.
    function automatic logic op_a_signed(input op_t op);
        return (op == OP_MULXSS) || (op == OP_MULXSU);
    endfunction

    // High-word ops that treat operand B as signed.
    function automatic logic op_b_signed(input op_t op);
        return (op == OP_MULXSS);
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl_if
// Bundles everything the sequencer talks to apart from clock and reset:
//   request channel : flush, req_valid, req_ready, req_op, req_src1, req_src2
//   result channel  : res_valid, res_ready, res_data
//   cell channel    : cell_src1, cell_src2, cell_en (to cell),
//                     cell_p1, cell_p2, cell_p3 (registered products from cell)
// Modports:
//   master : requester / result consumer / multiply cell side
//   slave  : the sequencer (mul_seq_ctrl)
// -----------------------------------------------------------------------------
interface mul_seq_ctrl_if;
    import mul_seq_ctrl_pkg::*;

    logic          flush;
    logic          req_valid;
    logic          req_ready;
    op_t           req_op;
    word_t         req_src1;
    word_t         req_src2;

    logic          res_valid;
    logic          res_ready;
    word_t         res_data;

    word_t         cell_src1;
    word_t         cell_src2;
    logic          cell_en;
    logic [31:0]   cell_p1;
    logic [31:0]   cell_p2;
    logic [31:0]   cell_p3;

    modport master (
        output flush,
        output req_valid,
        output req_op,
        output req_src1,
        output req_src2,
        input  req_ready,
        input  res_valid,
        input  res_data,
        output res_ready,
        input  cell_src1,
        input  cell_src2,
        input  cell_en,
        output cell_p1,
        output cell_p2,
        output cell_p3
    );

    modport slave (
        input  flush,
        input  req_valid,
        input  req_op,
        input  req_src1,
        input  req_src2,
        output req_ready,
        output res_valid,
        output res_data,
        input  res_ready,
        output cell_src1,
        output cell_src2,
        output cell_en,
        input  cell_p1,
        input  cell_p2,
        input  cell_p3
    );

endinterface

// File: rtl/mul_seq_hi_fix.sv
// -----------------------------------------------------------------------------
// mul_seq_hi_fix
// Purely combinational signed correction of the unsigned high product word.
// A two's-complement operand X equals X_unsigned - X[31]*2^32, so the signed
// high word is the unsigned one minus B when A is negative (A signed) and
// minus A when B is negative (B signed). All arithmetic wraps mod 2^32.
// Ports:
//   i_hu  : unsigned high word of A*B
//   i_a   : operand A
//   i_b   : operand B
//   i_op  : opcode (MUL is treated as unsigned; its output is not used)
//   o_hi  : corrected high word
// -----------------------------------------------------------------------------
module mul_seq_hi_fix
    import mul_seq_ctrl_pkg::*;
(
    input  word_t i_hu,
    input  word_t i_a,
    input  word_t i_b,
    input  op_t   i_op,
    output word_t o_hi
);

    word_t w_sub_a;
    word_t w_sub_b;

    always_comb begin
        w_sub_a = '0;
        w_sub_b = '0;
        if (op_a_signed(i_op) && i_a[DATA_W-1]) begin
            w_sub_a = i_b;
        end
        if (op_b_signed(i_op) && i_b[DATA_W-1]) begin
            w_sub_b = i_a;
        end
        o_hi = i_hu - w_sub_a - w_sub_b;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
// Sequencer and result combiner for the three-product 16x16 multiply cell.
// Pass 1 issues the full operands and captures p1=lo*lo, p2=lo*hi, p3=hi*lo,
// giving the low word and the carry into the high word. High-word ops then run
// pass 2, reusing the p1 slot for a_hi*b_hi, add the carry and apply the
// signed correction.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (the cell shares it)
//   bus      : mul_seq_ctrl_if.slave -- request, result and cell channels
// Latency from accept edge: MUL reaches DONE in the 3rd cycle, MULX* in the 5th.
// -----------------------------------------------------------------------------
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    mul_seq_ctrl_if.slave bus
);

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    word_t               r_a;
    word_t               r_b;
    op_t                 r_op;
    logic [CARRY_W-1:0]  r_carry;
    word_t               r_res_data;

    logic                w_accept;
    logic [33:0]         w_sum;
    word_t               w_lo;
    word_t               w_hu;
    word_t               w_hi;

    // A flush in IDLE wins over a coincident request, so that request is dropped.
    assign w_accept = (r_state == ST_IDLE) && bus.req_valid && !bus.flush;

    // S = p1[31:16] + p2 + p3. Its low half is the upper 16 bits of the low
    // word; everything above bit 16 carries into the high word.
    assign w_sum = {18'b0, bus.cell_p1[31:HALF_W]}
                 + {2'b0, bus.cell_p2}
                 + {2'b0, bus.cell_p3};
    assign w_lo  = {w_sum[HALF_W-1:0], bus.cell_p1[HALF_W-1:0]};

    // In pass 2 the p1 slot holds a_hi*b_hi.
    assign w_hu  = bus.cell_p1 + {{(DATA_W-CARRY_W){1'b0}}, r_carry};

    mul_seq_hi_fix u_hi_fix (
        .i_hu (w_hu),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_hi (w_hi)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_state_next = ST_ISSUE1;
                end
            end
            ST_ISSUE1: w_state_next = ST_CAP1;
            ST_CAP1: begin
                if (r_op == OP_MUL) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_ISSUE2;
                end
            end
            ST_ISSUE2: w_state_next = ST_CAP2;
            ST_CAP2:   w_state_next = ST_DONE;
            ST_DONE: begin
                if (bus.res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:   w_state_next = ST_IDLE;
        endcase
        if (bus.flush) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_MUL;
            r_carry    <= '0;
            r_res_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a  <= bus.req_src1;
                r_b  <= bus.req_src2;
                r_op <= bus.req_op;
            end
            if (r_state == ST_CAP1) begin
                r_carry <= w_sum[33:HALF_W];
                if (r_op == OP_MUL) begin
                    r_res_data <= w_lo;
                end
            end
            if (r_state == ST_CAP2) begin
                r_res_data <= w_hi;
            end
        end
    end

    // Cell operands are parked at zero outside the issue states.
    always_comb begin
        bus.cell_src1 = '0;
        bus.cell_src2 = '0;
        case (r_state)
            ST_ISSUE1: begin
                bus.cell_src1 = r_a;
                bus.cell_src2 = r_b;
            end
            ST_ISSUE2: begin
                bus.cell_src1 = {{HALF_W{1'b0}}, r_a[DATA_W-1:HALF_W]};
                bus.cell_src2 = {{HALF_W{1'b0}}, r_b[DATA_W-1:HALF_W]};
            end
            default: begin
                bus.cell_src1 = '0;
                bus.cell_src2 = '0;
            end
        endcase
    end

    assign bus.cell_en   = (r_state == ST_ISSUE1) || (r_state == ST_ISSUE2);
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.res_valid = (r_state == ST_DONE);
    assign bus.res_data  = r_res_data;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl
// Directed and random stimulus for mul_seq_ctrl. Includes a behavioural model
// of the registered multiply cell and a 64-bit arithmetic reference for results.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;
    import mul_seq_ctrl_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl_if bus_if ();

    mul_seq_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    // Multiply cell: three registered 16x16 products, latency 1, shared reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_if.cell_p1 <= '0;
            bus_if.cell_p2 <= '0;
            bus_if.cell_p3 <= '0;
        end else if (bus_if.cell_en) begin
            bus_if.cell_p1 <= {16'b0, bus_if.cell_src1[15:0]}  * {16'b0, bus_if.cell_src2[15:0]};
            bus_if.cell_p2 <= {16'b0, bus_if.cell_src1[15:0]}  * {16'b0, bus_if.cell_src2[31:16]};
            bus_if.cell_p3 <= {16'b0, bus_if.cell_src1[31:16]} * {16'b0, bus_if.cell_src2[15:0]};
        end
    end

    // Reference: full 64-bit product of the operands extended per signedness.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] prod;
        ea = {32'b0, a};
        eb = {32'b0, b};
        if ((op == OP_MULXSS || op == OP_MULXSU) && a[31]) ea[63:32] = 32'hFFFF_FFFF;
        if (op == OP_MULXSS && b[31]) eb[63:32] = 32'hFFFF_FFFF;
        prod = ea * eb;
        return (op == OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; returns after the accept edge (+1).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_src1  = a;
        bus_if.req_src2  = b;
        @(posedge clk);
        #1;
        // Scramble the request bus; only the accept-time values may be used.
        bus_if.req_valid = 1'b0;
        bus_if.req_op    = 2'($urandom);
        bus_if.req_src1  = $urandom;
        bus_if.req_src2  = $urandom;
    endtask

    // Full transaction with latency, cell_en and backpressure checks.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        int          cyc;
        int          en_cnt;
        logic [31:0] exp;
        exp = ref_result(op, a, b);
        @(negedge clk);
        check_bit($sformatf("%s req_ready idle", tag), bus_if.req_ready, 1'b1);
        bus_if.res_ready = 1'b0;
        issue(op, a, b);
        cyc    = 0;
        en_cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus_if.cell_en) en_cnt++;
        end while (!bus_if.res_valid && cyc < 20);
        check($sformatf("%s latency", tag), cyc, (op == OP_MUL) ? 3 : 5);
        check($sformatf("%s cell_en cycles", tag), en_cnt, (op == OP_MUL) ? 1 : 2);
        check($sformatf("%s res_data", tag), bus_if.res_data, exp);
        for (int i = 0; i < stall; i++) begin
            // A request during DONE must be ignored.
            bus_if.req_valid = 1'b1;
            bus_if.req_src1  = $urandom;
            @(negedge clk);
            check_bit($sformatf("%s stall%0d res_valid", tag, i), bus_if.res_valid, 1'b1);
            check($sformatf("%s stall%0d res_data", tag, i), bus_if.res_data, exp);
            check_bit($sformatf("%s stall%0d req_ready", tag, i), bus_if.req_ready, 1'b0);
        end
        bus_if.res_ready = 1'b1;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.res_ready = 1'b0;
        check_bit($sformatf("%s res_valid after hs", tag), bus_if.res_valid, 1'b0);
        check_bit($sformatf("%s req_ready after hs", tag), bus_if.req_ready, 1'b1);
        @(negedge clk);
        check_bit($sformatf("%s still idle", tag), bus_if.req_ready, 1'b1);
    endtask

    initial begin
        logic seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus_if.flush     = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_op    = OP_MUL;
        bus_if.req_src1  = '0;
        bus_if.req_src2  = '0;
        bus_if.res_ready = 1'b0;

        // Reset values
        #2 reset_n = 1'b0;
        #1;
        check_bit("rst req_ready", bus_if.req_ready, 1'b1);
        check_bit("rst res_valid", bus_if.res_valid, 1'b0);
        check("rst res_data", bus_if.res_data, 32'h0);
        check_bit("rst cell_en", bus_if.cell_en, 1'b0);
        check("rst cell_src1", bus_if.cell_src1, 32'h0);
        check("rst cell_src2", bus_if.cell_src2, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors
        run_op("mul small",   OP_MUL,    32'h0001_0002, 32'h0003_0004, 0);
        check("mul small val", bus_if.res_data, 32'h000A_0008);
        run_op("mulxuu small", OP_MULXUU, 32'h0001_0002, 32'h0003_0004, 0);
        check("mulxuu small val", bus_if.res_data, 32'h0000_0003);
        run_op("mulxuu ones", OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulxuu ones val", bus_if.res_data, 32'hFFFF_FFFE);
        run_op("mul ones",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul ones val", bus_if.res_data, 32'h0000_0001);
        run_op("mulxss ones", OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulxss ones val", bus_if.res_data, 32'h0000_0000);
        run_op("mulxss min",  OP_MULXSS, 32'h8000_0000, 32'h0000_0002, 0);
        check("mulxss min val", bus_if.res_data, 32'hFFFF_FFFF);
        run_op("mulxsu ones", OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulxsu ones val", bus_if.res_data, 32'hFFFF_FFFF);
        run_op("mulxsu pos",  OP_MULXSU, 32'h0000_0002, 32'h8000_0000, 0);
        check("mulxsu pos val", bus_if.res_data, 32'h0000_0001);

        // Backpressure: four cycles held in DONE
        run_op("bp mulxss", OP_MULXSS, 32'h1234_5678, 32'h8765_4321, 4);

        // Flush in CAP1 of a MULXUU
        issue(OP_MULXUU, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        @(negedge clk);
        @(negedge clk);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        check_bit("flush req_ready", bus_if.req_ready, 1'b1);
        check_bit("flush cell_en", bus_if.cell_en, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus_if.res_valid) seen = 1'b1;
            @(negedge clk);
        end
        check_bit("flush no result", seen, 1'b0);
        run_op("after flush", OP_MUL, 32'd7, 32'd6, 0);
        check("after flush val", bus_if.res_data, 32'h0000_002A);

        // Flush drops a pending result in DONE
        bus_if.res_ready = 1'b0;
        issue(OP_MUL, 32'd3, 32'd5);
        repeat (3) @(negedge clk);
        check_bit("done before flush", bus_if.res_valid, 1'b1);
        bus_if.flush     = 1'b1;
        bus_if.res_ready = 1'b1;
        @(negedge clk);
        bus_if.flush     = 1'b0;
        bus_if.res_ready = 1'b0;
        check_bit("flush in done res_valid", bus_if.res_valid, 1'b0);
        check_bit("flush in done req_ready", bus_if.req_ready, 1'b1);

        // Reset in ISSUE2
        issue(OP_MULXSS, 32'h8000_0001, 32'h7FFF_FFFF);
        repeat (3) @(negedge clk);
        check_bit("issue2 cell_en", bus_if.cell_en, 1'b1);
        reset_n = 1'b0;
        #1;
        check_bit("midrst req_ready", bus_if.req_ready, 1'b1);
        check_bit("midrst res_valid", bus_if.res_valid, 1'b0);
        check("midrst res_data", bus_if.res_data, 32'h0);
        check_bit("midrst cell_en", bus_if.cell_en, 1'b0);
        check("midrst cell_src1", bus_if.cell_src1, 32'h0);
        check("midrst cell_src2", bus_if.cell_src2, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("after rst", OP_MULXSU, 32'hFFFF_FFFE, 32'h0000_0003, 1);

        // Random operations against the reference
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (n % 6 == 0) ra = 32'h8000_0000;
            if (n % 7 == 0) rb = 32'hFFFF_FFFF;
            run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
